// File: rtl/sort_pkg.sv
// sort_pkg: shared constants and types for the sort_loader / sort_buf slice
// that feeds the 32-entry bubble-sort block.
package sort_pkg;

    localparam int N_ELEM      = 32;     // entries per frame (sorter width)
    localparam int ELEM_W      = 7;      // bits per entry
    localparam int FRAME_CNT_W = 8;      // completed-frame counter width

    // Fill value for short frames; all-ones so padding sorts to the top.
    localparam logic [ELEM_W-1:0] PAD_VAL = 7'h7F;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/sort_buf.sv
// sort_buf: N_ELEM x ELEM_W frame register array. One write port, an
// optional pad-fill of every entry above the written index, a synchronous
// clear, and the whole array presented as a flat bus (entry 0 in the LSBs).
module sort_buf #(
    parameter int N_ELEM = sort_pkg::N_ELEM,
    parameter int ELEM_W = sort_pkg::ELEM_W,
    localparam int IDX_W = $clog2(N_ELEM)
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     we,
    input  logic [IDX_W-1:0]         idx,
    input  logic [ELEM_W-1:0]        data,
    input  logic                     pad,
    output logic [N_ELEM*ELEM_W-1:0] a_flat
);
    import sort_pkg::*;

    // Frame storage: clear wins; otherwise write entry idx and, when pad is
    // set, fill every higher entry with PAD_VAL on the same edge.
    // NOTE: this array is cleared on reset on purpose -- a reset must discard
    // a partial frame and present zeros, so it cannot be left unreset like RAM.
    always_ff @(posedge clk) begin
        if (clear) begin
            a_flat <= '0;
        end else if (we) begin
            for (int i = 0; i < N_ELEM; i++) begin
                if (IDX_W'(i) == idx) begin
                    a_flat[i*ELEM_W +: ELEM_W] <= data;
                end else if (pad && (IDX_W'(i) > idx)) begin
                    a_flat[i*ELEM_W +: ELEM_W] <= ELEM_W'(PAD_VAL);
                end
            end
        end
    end

endmodule

// File: rtl/sort_loader.sv
// sort_loader: collects a serial valid/ready stream of ELEM_W-bit values into
// one N_ELEM-entry frame, presents it on a_flat, pulses start, waits for the
// sorter's sort_done level, pulses ack and reopens for the next frame.
// Optional feature macro: SORT_LOADER_PAD_EN adds in_last, which ends a frame
// early and pads the remaining entries with PAD_VAL.
module sort_loader #(
    parameter int N_ELEM = sort_pkg::N_ELEM,
    parameter int ELEM_W = sort_pkg::ELEM_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic [ELEM_W-1:0]                 in_data,
`ifdef SORT_LOADER_PAD_EN
    input  logic                              in_last,
`endif
    output logic                              in_ready,
    output logic [N_ELEM*ELEM_W-1:0]          a_flat,
    output logic                              start,
    input  logic                              sort_done,
    output logic                              ack,
    output logic                              busy,
    output logic [sort_pkg::FRAME_CNT_W-1:0]  frame_cnt
);
    import sort_pkg::*;

    localparam int               IDX_W    = $clog2(N_ELEM);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

    loader_state_t    state;
    logic [IDX_W-1:0] idx;
    logic             xfer;
    logic             pad_req;
    logic             frame_end;

`ifdef SORT_LOADER_PAD_EN
    assign pad_req = in_last;
`else
    assign pad_req = 1'b0;
`endif

    // Ready only while loading, and never while reset is asserted.
    assign in_ready  = (state == LOAD) && !reset;
    assign xfer      = in_valid && in_ready;
    assign frame_end = (idx == IDX_LAST) || pad_req;

    // Control FSM, write index and completed-frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= LOAD;
            idx       <= '0;
            start     <= 1'b0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout: every branch below
            // reads the pre-edge state, and these defaults make start/ack
            // single-cycle pulses unless a branch re-asserts them.
            start <= 1'b0;
            ack   <= 1'b0;
            case (state)
                LOAD: begin
                    if (xfer) begin
                        if (frame_end) begin
                            state <= START;
                            idx   <= '0;
                            start <= 1'b1;
                            busy  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (sort_done) begin
                        state <= ACK;
                        ack   <= 1'b1;
                    end
                end
                ACK: begin
                    state     <= LOAD;
                    busy      <= 1'b0;
                    frame_cnt <= frame_cnt + 1'b1;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

    sort_buf #(
        .N_ELEM (N_ELEM),
        .ELEM_W (ELEM_W)
    ) u_buf (
        .clk    (clk),
        .clear  (reset),
        .we     (xfer),
        .idx    (idx),
        .data   (in_data),
        .pad    (pad_req),
        .a_flat (a_flat)
    );

endmodule

// File: tb/tb_sort_loader.sv
// tb_sort_loader: scoreboard bench for sort_loader. The driver records each
// accepted value in a frame-level model and queues the expected frame; a
// sorter model answers start with sort_done after a chosen latency and queues
// the expected ack cycle; a monitor pops and compares on start and ack.
module tb_sort_loader;
    import sort_pkg::*;

    localparam int FW     = N_ELEM * ELEM_W;
    localparam int BUDGET = 400;

    typedef struct {
        logic [FW-1:0] frame;
        int            edge_no;
    } exp_frame_t;

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic [ELEM_W-1:0]      in_data;
`ifdef SORT_LOADER_PAD_EN
    logic                   in_last;
`endif
    logic                   in_ready;
    logic [FW-1:0]          a_flat;
    logic                   start;
    logic                   sort_done;
    logic                   ack;
    logic                   busy;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    sort_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef SORT_LOADER_PAD_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .a_flat    (a_flat),
        .start     (start),
        .sort_done (sort_done),
        .ack       (ack),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    exp_frame_t exp_q[$];
    int         ack_q[$];
    int         lat_q[$];

    logic [FW-1:0] mdl_frame;
    int            mdl_cnt;

    int frame1 [N_ELEM] = '{30, 22, 23, 21, 13, 14, 16, 12, 20, 19, 28, 17, 27, 24, 18, 25,
                            26, 16,  9, 11,  6, 12, 31,  7,  8, 10,  5,  4,  3,  2,  1,  0};

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input string got, input string want);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %s, expected %s (cycle %0d)", name, got, want, cyc);
    endtask

    // Frame-level reference: accepted values fill the next slot; a full frame
    // (or an in_last beat, padded with PAD_VAL) becomes one expected frame.
    task automatic model_accept(input logic [ELEM_W-1:0] v, input bit last, input int edge_no);
        exp_frame_t e;
        mdl_frame[mdl_cnt*ELEM_W +: ELEM_W] = v;
        mdl_cnt++;
        if (last) begin
            for (int j = mdl_cnt; j < N_ELEM; j++) mdl_frame[j*ELEM_W +: ELEM_W] = PAD_VAL;
        end
        if (mdl_cnt == N_ELEM || last) begin
            e.frame   = mdl_frame;
            e.edge_no = edge_no;
            exp_q.push_back(e);
            mdl_cnt = 0;
        end
    endtask

    // Called and returns just after a rising edge (+1).
    task automatic send(input logic [ELEM_W-1:0] v, input bit last, input int gap);
        int b;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = v;
`ifdef SORT_LOADER_PAD_EN
        in_last  = last;
`endif
        @(negedge clk);
        b = 0;
        while (!in_ready && b < BUDGET) begin @(negedge clk); b++; end
        if (in_ready) model_accept(v, last, cyc + 1);
        else flag("accept_timeout", "in_ready low", "in_ready high");
        @(posedge clk); #1;
        in_valid = 1'b0;
`ifdef SORT_LOADER_PAD_EN
        in_last  = 1'b0;
`endif
    endtask

    task automatic drain();
        int b = 0;
        while ((exp_q.size() != 0 || ack_q.size() != 0 || busy || sort_done) && b < 2000) begin
            @(negedge clk);
            b++;
        end
        if (b >= 2000) flag("drain_timeout", "frames outstanding", "all frames acked");
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    // Sorter model: answer each start with sort_done after a queued latency,
    // hold it until ack, sometimes a little longer (must be ignored).
    initial begin
        int lat, extra, b;
        sort_done = 1'b0;
        forever begin
            @(negedge clk);
            if (start && !reset) begin
                lat = (lat_q.size() > 0) ? lat_q.pop_front() : 3;
                repeat (lat) @(negedge clk);
                sort_done = 1'b1;
                ack_q.push_back(cyc + 1);
                b = 0;
                do begin @(negedge clk); b++; end while (!ack && b < BUDGET);
                if (!ack) flag("ack_timeout", "ack low", "ack pulse");
                extra = $urandom_range(0, 2);
                repeat (extra) @(negedge clk);
                sort_done = 1'b0;
            end
        end
    end

    // Monitor: compare start/ack events and frame stability against the queues.
    logic             prev_start = 1'b0;
    logic             prev_ack   = 1'b0;
    logic             after_ack  = 1'b0;
    logic [FRAME_CNT_W-1:0] exp_fcnt = '0;
    logic [FW-1:0]    cur_frame  = '0;
    exp_frame_t       mon_e;

    always @(negedge clk) begin
        if (reset) begin
            exp_fcnt   = '0;
            prev_start = 1'b0;
            prev_ack   = 1'b0;
            after_ack  = 1'b0;
        end else begin
            if (after_ack) begin
                check("fcnt_after_ack", frame_cnt, exp_fcnt);
                check("ready_after_ack", in_ready, 1);
                check("busy_after_ack", busy, 0);
                after_ack = 1'b0;
            end
            if (start) begin
                check("start_one_cycle", prev_start, 0);
                if (exp_q.size() == 0) begin
                    flag("start_unexpected", "start pulse", "no start");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("start_time", cyc, mon_e.edge_no);
                    check("frame_at_start", a_flat, mon_e.frame);
                    cur_frame = mon_e.frame;
                end
                check("ready_in_start", in_ready, 0);
                check("busy_in_start", busy, 1);
            end else if (busy) begin
                check("frame_hold", a_flat, cur_frame);
            end
            if (ack) begin
                check("ack_one_cycle", prev_ack, 0);
                if (ack_q.size() == 0) flag("ack_unexpected", "ack pulse", "no ack");
                else check("ack_time", cyc, ack_q.pop_front());
                check("busy_in_ack", busy, 1);
                exp_fcnt  = exp_fcnt + 1'b1;
                after_ack = 1'b1;
            end
            prev_start = start;
            prev_ack   = ack;
        end
    end

    initial begin
        #300000;
        flag("watchdog", "still running", "finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
`ifdef SORT_LOADER_PAD_EN
        in_last   = 1'b0;
`endif
        mdl_frame = '0;
        mdl_cnt   = 0;

        // Reset values, reset held for two edges.
        #1;
        check("ready_in_reset", in_ready, 0);
        @(negedge clk);
        check("ready_in_reset2", in_ready, 0);
        check("rst_a_flat", a_flat, '0);
        check("rst_start", start, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);

        // Contiguous frame; first value offered on the first cycle after release.
        lat_q.push_back(10);
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = ELEM_W'(frame1[0]);
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);
        if (in_ready) model_accept(ELEM_W'(frame1[0]), 1'b0, cyc + 1);
        @(posedge clk); #1;
        for (int i = 1; i < N_ELEM; i++) send(ELEM_W'(frame1[i]), 1'b0, 0);

        // Backpressure: 99 offered throughout START/WAIT/ACK, lands as entry 0 next frame.
        lat_q.push_back($urandom_range(1, 6));
        send(7'd99, 1'b0, 0);
        for (int i = 1; i < N_ELEM; i++) send(ELEM_W'($urandom_range(0, 127)), 1'b0, 0);

        // Gapped input: in_valid toggles every cycle.
        lat_q.push_back($urandom_range(1, 6));
        for (int i = 0; i < N_ELEM; i++) send(ELEM_W'($urandom_range(0, 127)), 1'b0, 1);
        drain();
        check("fcnt_three", frame_cnt, 3);

        // Reset mid-load: partial frame discarded, counters cleared.
        for (int i = 0; i < 10; i++) send(ELEM_W'($urandom_range(0, 127)), 1'b0, 0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_in_midreset", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        mdl_cnt   = 0;
        mdl_frame = '0;
        @(negedge clk);
        check("midrst_a_flat", a_flat, '0);
        check("midrst_frame_cnt", frame_cnt, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", in_ready, 1);
        @(posedge clk); #1;

        // Full frame after reset with random gaps.
        lat_q.push_back($urandom_range(1, 8));
        for (int i = 0; i < N_ELEM; i++) send(ELEM_W'($urandom_range(0, 127)), 1'b0, $urandom_range(0, 2));

`ifdef SORT_LOADER_PAD_EN
        // Short frame ended by in_last; the rest pads with PAD_VAL.
        lat_q.push_back(2);
        send(7'd5, 1'b0, 0);
        send(7'd4, 1'b0, 0);
        send(7'd3, 1'b0, 0);
        send(7'd2, 1'b0, 0);
        send(7'd1, 1'b1, 0);
        // in_last on the final entry is a plain end of frame.
        lat_q.push_back(1);
        for (int i = 0; i < N_ELEM; i++) send(ELEM_W'($urandom_range(0, 127)), (i == N_ELEM - 1), 0);
`endif

        drain();
`ifdef SORT_LOADER_PAD_EN
        check("fcnt_final", frame_cnt, 3);
`else
        check("fcnt_final", frame_cnt, 1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
